// File: rtl/decision_tx_framer.sv
// decision_tx_framer: serializes one decision word into a byte frame for the TX MAC.
// Ports: clk/rst_n, in_* decision word (valid/ready), tx_* byte stream, frame_cnt/lat_last telemetry. Option: TX_TSTAMP_EN.
module decision_tx_framer #(
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_type,
  input  logic [31:0]      in_data,
  input  logic [31:0]      in_t_ingress,
  input  logic [31:0]      in_t_decision,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [31:0]      lat_last
);

`ifdef TX_TSTAMP_EN
  localparam int N = 12;
`else
  localparam int N = 8;
`endif
  localparam logic [3:0] LAST = 4'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]  state;
  logic [3:0]  idx;
  logic [7:0]  c_type;
  logic [31:0] c_data;
  logic [31:0] c_lat;
  logic [7:0]  seq;
  logic [7:0]  chk;
  logic [7:0]  fbyte;
  logic        send;

  assign send     = (state == SEND);
  // Held low while reset is asserted, not just after the first edge.
  assign in_ready = rst_n & ~send;
  assign tx_valid = send;
  assign tx_last  = send & (idx == LAST);
  assign tx_data  = send ? fbyte : 8'h00;

  always_comb begin
    chk = c_type
        ^ c_data[31:24] ^ c_data[23:16]
        ^ c_data[15:8]  ^ c_data[7:0]
        ^ seq;
`ifdef TX_TSTAMP_EN
    chk = chk
        ^ c_lat[31:24] ^ c_lat[23:16]
        ^ c_lat[15:8]  ^ c_lat[7:0];
`endif
  end

  always_comb begin
    fbyte = 8'h00;
    case (idx)
      4'd0: fbyte = SOF_BYTE;
      4'd1: fbyte = c_type;
      4'd2: fbyte = c_data[31:24];
      4'd3: fbyte = c_data[23:16];
      4'd4: fbyte = c_data[15:8];
      4'd5: fbyte = c_data[7:0];
      4'd6: fbyte = seq;
`ifdef TX_TSTAMP_EN
      4'd7:  fbyte = c_lat[31:24];
      4'd8:  fbyte = c_lat[23:16];
      4'd9:  fbyte = c_lat[15:8];
      4'd10: fbyte = c_lat[7:0];
      4'd11: fbyte = chk;
`else
      4'd7: fbyte = chk;
`endif
      default: fbyte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      c_type    <= 8'h00;
      c_data    <= 32'h0;
      c_lat     <= 32'h0;
      seq       <= 8'h00;
      frame_cnt <= '0;
      lat_last  <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            c_type <= in_type;
            c_data <= in_data;
            // Modulo-2^32 difference tolerates stamp counter wrap.
            c_lat  <= in_t_decision - in_t_ingress;
            idx    <= 4'd0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == LAST) begin
              state     <= IDLE;
              idx       <= 4'd0;
              seq       <= seq + 8'd1;
              frame_cnt <= frame_cnt + 1'b1;
              lat_last  <= c_lat;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decision_tx_framer.sv
// tb_decision_tx_framer: scoreboard + vector-table bench for decision_tx_framer.
// Drives decision words, checks every accepted byte, telemetry, stalls and resets.
module tb_decision_tx_framer;

`ifdef TX_TSTAMP_EN
  localparam int NB = 12;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_type = '0;
  logic [31:0] in_data = '0;
  logic [31:0] in_t_ingress = '0;
  logic [31:0] in_t_decision = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready = 1'b1;
  logic [15:0] frame_cnt;
  logic [31:0] lat_last;

  decision_tx_framer dut (
    .clk(clk), .rst_n(rst_n),
    .in_type(in_type), .in_data(in_data),
    .in_t_ingress(in_t_ingress), .in_t_decision(in_t_decision),
    .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .frame_cnt(frame_cnt), .lat_last(lat_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         last;
    bit         first;
  } exp_t;

  typedef struct {
    logic [7:0]  t;
    logic [31:0] d;
    logic [31:0] ti;
    logic [31:0] td;
    logic [31:0] lat;
  } vec_t;

  exp_t       sb[$];
  logic [7:0] got[$];
  int         total = 0;
  int         passed = 0;
  int         mcnt = 0;
  logic [7:0] mseq = 8'h00;
  int         cyc = 0;
  int         last_cyc = 0;
  bit         bb = 1'b0;
  bit         have_last = 1'b0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_frame(logic [7:0] t, logic [31:0] d,
                            logic [31:0] ti, logic [31:0] td);
    logic [7:0]  f[12];
    logic [31:0] lat;
    logic [7:0]  x;
    exp_t        e;
    lat = td - ti;
    foreach (f[i]) f[i] = 8'h00;
    f[0] = 8'hA5;
    f[1] = t;
    f[2] = d[31:24];
    f[3] = d[23:16];
    f[4] = d[15:8];
    f[5] = d[7:0];
    f[6] = mseq;
`ifdef TX_TSTAMP_EN
    f[7]  = lat[31:24];
    f[8]  = lat[23:16];
    f[9]  = lat[15:8];
    f[10] = lat[7:0];
`endif
    x = 8'h00;
    for (int i = 1; i <= NB - 2; i++) x ^= f[i];
    f[NB-1] = x;
    for (int i = 0; i < NB; i++) begin
      e.b = f[i];
      e.last = (i == NB - 1);
      e.first = (i == 0);
      sb.push_back(e);
    end
    mseq++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      cyc++;
      if (tx_valid) begin
        check("in_ready_in_send", in_ready, 0);
        if (tx_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_byte", tx_data, 0);
          end else begin
            e = sb.pop_front();
            check("tx_data", tx_data, e.b);
            check("tx_last", tx_last, e.last);
            got.push_back(tx_data);
            if (e.first && bb && have_last)
              check("idle_gap", cyc - last_cyc, 2);
            if (e.last) begin
              last_cyc = cyc;
              have_last = 1'b1;
              mcnt++;
            end
          end
        end
      end else begin
        check("idle_tx_data", tx_data, 0);
        check("idle_tx_last", tx_last, 0);
      end
    end
  end

  task automatic send(logic [7:0] t, logic [31:0] d,
                      logic [31:0] ti, logic [31:0] td);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_wait", in_ready, 1);
      return;
    end
    in_type = t;
    in_data = d;
    in_t_ingress = ti;
    in_t_decision = td;
    in_valid = 1'b1;
    push_frame(t, d, ti, td);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || tx_valid) && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  vec_t vt[4];

  initial begin
    vt[0] = '{8'h01, 32'hDEADBEEF, 32'h00000100, 32'h000001FF, 32'h000000FF};
    vt[1] = '{8'hFF, 32'h00000000, 32'hFFFFFFF0, 32'h00000010, 32'h00000020};
    vt[2] = '{8'h00, 32'hFFFFFFFF, 32'h00000005, 32'h00000005, 32'h00000000};
    vt[3] = '{8'h7E, 32'hA5A5A5A5, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF};

    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_last", tx_last, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_lat_last", lat_last, 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // First frame against the literal byte sequence.
    got.delete();
    send(8'h42, 32'h11223344, 32'h0, 32'h0);
    wait_done();
    check("frame_cnt_1", frame_cnt, 1);
`ifndef TX_TSTAMP_EN
    begin
      logic [7:0] ref1[8];
      ref1 = '{8'hA5, 8'h42, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h06};
      check("f1_len", got.size(), 8);
      for (int i = 0; i < 8 && i < got.size(); i++)
        check($sformatf("f1_byte%0d", i), got[i], ref1[i]);
    end
`endif

    // Vector table: latency and counters.
    for (int k = 0; k < 4; k++) begin
      send(vt[k].t, vt[k].d, vt[k].ti, vt[k].td);
      wait_done();
      check($sformatf("lat_last_v%0d", k), lat_last, vt[k].lat);
      check($sformatf("frame_cnt_v%0d", k), frame_cnt, mcnt);
    end

    // Stall while byte 3 is presented.
    send(8'h42, 32'h11223344, 32'h0, 32'h0);
    repeat (3) begin @(posedge clk); #2; end
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      check("stall_data", tx_data, 8'h22);
      check("stall_valid", tx_valid, 1);
      check("stall_last", tx_last, 0);
    end
    tx_ready = 1'b1;
    wait_done();
    check("stall_frame_cnt", frame_cnt, mcnt);

    // Noisy inputs during SEND must not disturb the captured word.
    send(8'h5A, 32'hCAFEF00D, 32'h10, 32'h30);
    for (int n = 0; n < 40 && tx_valid; n++) begin
      if (tx_last) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_type = 8'($urandom);
        in_data = $urandom;
        in_t_ingress = $urandom;
        in_t_decision = $urandom;
      end
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    wait_done();
    check("noisy_lat", lat_last, 32'h20);
    check("noisy_cnt", frame_cnt, mcnt);

    // Reset in the middle of a frame.
    send(8'h33, 32'h01020304, 32'h0, 32'h1);
    repeat (4) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_in_ready", in_ready, 0);
    sb.delete();
    got.delete();
    mseq = 8'h00;
    mcnt = 0;
    have_last = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    send(8'h42, 32'h11223344, 32'h0, 32'h0);
    wait_done();
    check("post_rst_len", got.size(), NB);
    if (got.size() >= 7) begin
      check("post_rst_sof", got[0], 8'hA5);
      check("post_rst_seq", got[6], 8'h00);
    end
    check("post_rst_cnt", frame_cnt, 1);

    // 257 back-to-back frames: seq wraps, single idle cycle between frames.
    bb = 1'b1;
    have_last = 1'b0;
    for (int k = 0; k < 257; k++)
      send(8'(k), 32'(k * 32'h01010101), 32'(k), 32'(2 * k));
    wait_done();
    bb = 1'b0;
    check("b2b_cnt", frame_cnt, mcnt);
    check("b2b_lat", lat_last, 32'd256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
